// File: rtl/fpu_defs_pkg.sv
// fpu_defs_pkg: shared FPU rounding-mode encodings, float format defaults and width helpers.
package fpu_defs_pkg;
    localparam logic [1:0] C_RM_NEAREST  = 2'd0;
    localparam logic [1:0] C_RM_TRUNC    = 2'd1;
    localparam logic [1:0] C_RM_PLUSINF  = 2'd2;
    localparam logic [1:0] C_RM_MINUSINF = 2'd3;
    localparam int C_INT_DEFAULT  = 32;
    localparam int C_EXP_DEFAULT  = 8;
    localparam int C_MANT_DEFAULT = 23;
    localparam int C_BIAS_DEFAULT = 127;
    localparam int C_RM_DEFAULT   = 2;
    function automatic int lzc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int res_width(input int e, input int m);
        return 1 + e + m;
    endfunction
    localparam int C_LZC_W_DEFAULT = lzc_width(C_INT_DEFAULT);
    localparam int C_RES_W_DEFAULT = res_width(C_EXP_DEFAULT, C_MANT_DEFAULT);
endpackage

// File: rtl/fpu_lzc_n.sv
// fpu_lzc_n: combinational leading-zero counter of parametrised width.
module fpu_lzc_n import fpu_defs_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = lzc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);
    // the highest set bit is visited last and therefore wins
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++)
            if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
    assign zero_o = ~|data_i;
endmodule

// File: rtl/fpu_itof_pipe.sv
// fpu_itof_pipe: three-stage integer-to-float converter (capture, normalise, round/pack)
// with valid/ready handshakes on both sides.
module fpu_itof_pipe import fpu_defs_pkg::*; #(
    parameter int C_INT  = C_INT_DEFAULT,
    parameter int C_EXP  = C_EXP_DEFAULT,
    parameter int C_MANT = C_MANT_DEFAULT,
    parameter int C_BIAS = C_BIAS_DEFAULT,
    parameter int C_RM   = C_RM_DEFAULT
) (
    input  logic                                  Clk_CI,
    input  logic                                  Rst_RBI,
    input  logic [C_INT-1:0]                      Operand_a_DI,
    input  logic                                  Signed_SI,
    input  logic [C_RM-1:0]                       RM_SI,
    input  logic                                  Valid_SI,
    output logic                                  Ready_SO,
    output logic [res_width(C_EXP, C_MANT)-1:0]   Result_DO,
    output logic                                  Inexact_SO,
    output logic                                  Valid_SO,
    input  logic                                  Ready_SI
);
    localparam int LZC_W = lzc_width(C_INT);
    localparam int EXT_W = C_INT + C_MANT + 2;

    logic                    v1_q, v1_d, sign1_q, sign1_d;
    logic [C_INT-1:0]        mag1_q, mag1_d;
    logic [C_RM-1:0]         rm1_q, rm1_d, rm2_q, rm2_d;
    logic                    v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d;
    logic [C_INT-1:0]        norm2_q, norm2_d;
    logic [C_EXP-1:0]        exp2_q, exp2_d;
    logic                    v3_q, v3_d, inx3_q, inx3_d;
    logic [C_EXP+C_MANT:0]   res3_q, res3_d;
    logic                    en1, en2, en3, ld1, ld2, ld3, neg;
    logic [LZC_W-1:0]        lzc_cnt;
    logic                    lzc_zero;
    logic [EXT_W-1:0]        ext;
    logic [C_MANT-1:0]       field;
    logic                    guard, sticky, up, carry;

    fpu_lzc_n #(.WIDTH(C_INT), .CNT_W(LZC_W)) u_lzc (
        .data_i (mag1_q),
        .cnt_o  (lzc_cnt),
        .zero_o (lzc_zero)
    );

    always_comb begin
        en3 = ~v3_q | Ready_SI;
        en2 = ~v2_q | en3;
        en1 = ~v1_q | en2;
        ld1 = en1 & Valid_SI;
        ld2 = en2 & v1_q;
        ld3 = en3 & v2_q;
        neg = Signed_SI & Operand_a_DI[C_INT-1];
        v1_d    = en1 ? Valid_SI : v1_q;
        sign1_d = ld1 ? neg : sign1_q;
        mag1_d  = ld1 ? (neg ? -Operand_a_DI : Operand_a_DI) : mag1_q;
        rm1_d   = ld1 ? RM_SI : rm1_q;
        v2_d    = en2 ? v1_q : v2_q;
        sign2_d = ld2 ? sign1_q : sign2_q;
        norm2_d = ld2 ? mag1_q << lzc_cnt : norm2_q;
        exp2_d  = ld2 ? C_EXP'(C_BIAS + C_INT - 1) - C_EXP'(lzc_cnt) : exp2_q;
        zero2_d = ld2 ? lzc_zero : zero2_q;
        rm2_d   = ld2 ? rm1_q : rm2_q;
        // pad below the normalised value so guard/sticky exist even for narrow integers
        ext    = {norm2_q, {(C_MANT + 2){1'b0}}};
        field  = ext[EXT_W-2 -: C_MANT];
        guard  = ext[EXT_W-C_MANT-2];
        sticky = |ext[EXT_W-C_MANT-3:0];
        up = (rm2_q == C_RM'(C_RM_NEAREST))  ? guard & (sticky | field[0]) :
             (rm2_q == C_RM'(C_RM_PLUSINF))  ? ~sign2_q & (guard | sticky) :
             (rm2_q == C_RM'(C_RM_MINUSINF)) ? sign2_q & (guard | sticky) : 1'b0;
        carry  = ext[EXT_W-1] & (&field) & up;
        v3_d   = en3 ? v2_q : v3_q;
        res3_d = ~ld3 ? res3_q : zero2_q ? '0 :
                 {sign2_q, exp2_q + C_EXP'(carry), field + C_MANT'(up)};
        inx3_d = ld3 ? ~zero2_q & (guard | sticky) : inx3_q;
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            mag1_q  <= '0;
            rm1_q   <= '0;
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            norm2_q <= '0;
            exp2_q  <= '0;
            zero2_q <= 1'b0;
            rm2_q   <= '0;
            v3_q    <= 1'b0;
            res3_q  <= '0;
            inx3_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            sign1_q <= sign1_d;
            mag1_q  <= mag1_d;
            rm1_q   <= rm1_d;
            v2_q    <= v2_d;
            sign2_q <= sign2_d;
            norm2_q <= norm2_d;
            exp2_q  <= exp2_d;
            zero2_q <= zero2_d;
            rm2_q   <= rm2_d;
            v3_q    <= v3_d;
            res3_q  <= res3_d;
            inx3_q  <= inx3_d;
        end
    end

    assign Ready_SO   = en1;
    assign Valid_SO   = v3_q;
    assign Result_DO  = res3_q;
    assign Inexact_SO = inx3_q;
endmodule

// File: tb/tb_fpu_itof_pipe.sv
// tb_fpu_itof_pipe: scoreboard bench for the float32 integer converter with an arithmetic reference model.
module tb_fpu_itof_pipe;
    logic        Clk_CI = 1'b0;
    logic        Rst_RBI = 1'b0;
    logic [31:0] a = '0;
    logic        s = 1'b0;
    logic [1:0]  rm = '0;
    logic        vi = 1'b0;
    logic        ro;
    logic [31:0] res;
    logic        inx;
    logic        vo;
    logic        ri = 1'b1;

    typedef struct {
        logic [31:0] r;
        logic        x;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] op;
        logic        sg;
        logic [1:0]  m;
        logic [31:0] r;
        logic        x;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    bit          rnd_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic        prev_inx;

    fpu_itof_pipe dut (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .Operand_a_DI (a),
        .Signed_SI    (s),
        .RM_SI        (rm),
        .Valid_SI     (vi),
        .Ready_SO     (ro),
        .Result_DO    (res),
        .Inexact_SO   (inx),
        .Valid_SO     (vo),
        .Ready_SI     (ri)
    );

    always #5 Clk_CI = ~Clk_CI;

    always @(posedge Clk_CI) if (rnd_rdy) #1 ri = ($urandom_range(0, 2) != 0);

    // value-level reference: scale the magnitude to 24 significant bits and round the remainder
    function automatic void model(input logic [31:0] op, input logic sg, input logic [1:0] m,
                                  output logic [31:0] r, output logic x);
        longint mag, q, rem, half;
        int     e, sh;
        logic   neg, up;
        neg = sg & op[31];
        mag = neg ? -longint'($signed(op)) : longint'({32'b0, op});
        r = '0;
        x = 1'b0;
        if (mag == 0) return;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        sh = e - 23;
        if (sh > 0) begin
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
        end else begin
            q    = mag << (-sh);
            rem  = 0;
            half = 1;
        end
        x = (rem != 0);
        case (m)
            2'd0:    up = (rem > half) || (rem == half && q[0]);
            2'd2:    up = !neg && x;
            2'd3:    up = neg && x;
            default: up = 1'b0;
        endcase
        q = q + longint'(up);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        r = {neg, 8'(e + 127), 23'(q)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] op, input logic sg, input logic [1:0] m,
                        input logic [31:0] er, input logic ex);
        @(posedge Clk_CI);
        #1;
        a  = op;
        s  = sg;
        rm = m;
        vi = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge Clk_CI);
            if (ro) break;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout op %h", op);
                return;
            end
        end
        sb.push_back('{er, ex});
    endtask

    task automatic send_model(input logic [31:0] op, input logic sg, input logic [1:0] m);
        logic [31:0] r;
        logic        x;
        model(op, sg, m, r, x);
        send(op, sg, m, r, x);
    endtask

    task automatic idle();
        @(posedge Clk_CI);
        #1;
        vi = 1'b0;
        a  = $urandom;
        s  = 1'($urandom);
        rm = 2'($urandom);
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 2000 && sb.size() != 0; n++) @(negedge Clk_CI);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge Clk_CI) begin
        exp_t e;
        if (!Rst_RBI) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!vo || res !== prev_res || inx !== prev_inx) begin
                    errors++;
                    $display("FAIL hold got v%b %h/%b want v1 %h/%b", vo, res, inx, prev_res, prev_inx);
                end
            end
            prev_stall = vo & ~ri;
            prev_res   = res;
            prev_inx   = inx;
            if (vo && ri) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %h want none", res);
                end else begin
                    e = sb.pop_front();
                    if (res !== e.r || inx !== e.x) begin
                        errors++;
                        $display("FAIL result got %h/%b want %h/%b", res, inx, e.r, e.x);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   n;
        vecs = '{
            '{32'h00000001, 1'b1, 2'd0, 32'h3F800000, 1'b0},
            '{32'hFFFFFFFF, 1'b1, 2'd0, 32'hBF800000, 1'b0},
            '{32'h80000000, 1'b1, 2'd0, 32'hCF000000, 1'b0},
            '{32'h80000000, 1'b1, 2'd1, 32'hCF000000, 1'b0},
            '{32'h80000000, 1'b1, 2'd2, 32'hCF000000, 1'b0},
            '{32'h80000000, 1'b1, 2'd3, 32'hCF000000, 1'b0},
            '{32'h80000000, 1'b0, 2'd0, 32'h4F000000, 1'b0},
            '{32'h01000001, 1'b0, 2'd0, 32'h4B800000, 1'b1},
            '{32'h01000001, 1'b0, 2'd1, 32'h4B800000, 1'b1},
            '{32'h01000001, 1'b0, 2'd2, 32'h4B800001, 1'b1},
            '{32'h01000001, 1'b0, 2'd3, 32'h4B800000, 1'b1},
            '{32'hFFFFFFFF, 1'b0, 2'd0, 32'h4F800000, 1'b1},
            '{32'hFFFFFFFF, 1'b0, 2'd1, 32'h4F7FFFFF, 1'b1},
            '{32'hFEFFFFFF, 1'b1, 2'd3, 32'hCB800001, 1'b1},
            '{32'hFEFFFFFF, 1'b1, 2'd2, 32'hCB800000, 1'b1},
            '{32'h00000000, 1'b0, 2'd0, 32'h00000000, 1'b0},
            '{32'h00000000, 1'b0, 2'd1, 32'h00000000, 1'b0},
            '{32'h00000000, 1'b1, 2'd2, 32'h00000000, 1'b0},
            '{32'h00000000, 1'b1, 2'd3, 32'h00000000, 1'b0}
        };
        repeat (3) @(posedge Clk_CI);
        @(negedge Clk_CI);
        chk("reset_valid", 32'(vo), 32'd0);
        chk("reset_result", res, 32'h0);
        chk("reset_inexact", 32'(inx), 32'd0);
        @(posedge Clk_CI);
        #1 Rst_RBI = 1'b1;
        @(negedge Clk_CI);
        chk("ready_after_reset", 32'(ro), 32'd1);
        chk("valid_after_reset", 32'(vo), 32'd0);

        foreach (vecs[i]) send(vecs[i].op, vecs[i].sg, vecs[i].m, vecs[i].r, vecs[i].x);
        idle();
        drain();

        send(32'd5, 1'b0, 2'd0, 32'h40A00000, 1'b0);
        idle();
        for (n = 1; n < 20; n++) begin
            @(negedge Clk_CI);
            if (vo) break;
        end
        chk("latency", 32'(n), 32'd3);
        drain();

        rnd_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] op;
            case ($urandom_range(0, 4))
                0:       op = $urandom;
                1:       op = 32'($urandom_range(0, 255));
                2:       op = (32'd1 << $urandom_range(0, 31)) - 32'($urandom_range(0, 1));
                3:       op = $urandom & 32'h81FFFFFF;
                default: op = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h0;
            endcase
            if ($urandom_range(0, 3) == 0) idle();
            send_model(op, 1'($urandom), 2'($urandom));
        end
        idle();
        rnd_rdy = 1'b0;
        @(posedge Clk_CI);
        #2 ri = 1'b1;
        drain();

        @(posedge Clk_CI);
        #1 ri = 1'b0;
        for (int k = 0; k < 3; k++) send_model($urandom, 1'($urandom), 2'($urandom));
        idle();
        @(negedge Clk_CI);
        chk("full_stalled_valid", 32'(vo), 32'd1);
        @(posedge Clk_CI);
        #1 Rst_RBI = 1'b0;
        sb.delete();
        @(posedge Clk_CI);
        #1;
        Rst_RBI = 1'b1;
        ri = 1'b1;
        @(negedge Clk_CI);
        chk("ready_after_flush", 32'(ro), 32'd1);
        repeat (8) begin
            chk("no_output_after_flush", 32'(vo), 32'd0);
            @(negedge Clk_CI);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_itof_pipe.md
Name: fpu_itof_pipe

Overview:
- Parametrised, pipelined successor to the combinational int-to-float prenormaliser.
- Takes a C_INT-bit signed or unsigned integer and produces a fully normalised, rounded and packed IEEE-754 result.
- Does its own leading-one detection, shifting, rounding under all four C_RM modes, and flag generation.
- Sits in the FPU next to the add/mul units, behind the FPU operand mux, with a valid/ready handshake on both sides.

Parameters:
- C_INT, 32: integer operand width; must be ≥ 2.
- C_EXP, 8: exponent field width.
- C_MANT, 23: mantissa field width, hidden bit excluded.
- C_BIAS, 127: exponent bias. Legality constraint: C_BIAS + C_INT ≤ 2^C_EXP − 2, so overflow cannot occur.
- C_RM, 2: rounding-mode field width.

Ports:
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  synchronous active-low reset.
- Operand_a_DI  in  C_INT  integer operand.
- Signed_SI  in  1  1: treat operand as two's complement; 0: treat as unsigned.
- RM_SI  in  C_RM  rounding mode: 0 nearest-even, 1 trunc, 2 +inf, 3 −inf.
- Valid_SI  in  1  input valid.
- Ready_SO  out  1  block can accept an input.
- Result_DO  out  1+C_EXP+C_MANT  packed float result.
- Inexact_SO  out  1  result was rounded.
- Valid_SO  out  1  output valid.
- Ready_SI  in  1  downstream accepts the output.

Behaviour:
- Three pipeline stages; each stage register holds a valid bit.
  - S1 (capture): sign = Signed_SI & MSB; magnitude = |operand| as C_INT-bit unsigned. The most negative value gives 2^(C_INT−1) correctly with no wrap. RM is captured alongside.
  - S2 (normalise): lzc = leading-zero count of the magnitude. Shift left by lzc. exp = C_BIAS + C_INT − 1 − lzc. Zero flag set if the magnitude is 0.
  - S3 (round/pack): keep C_MANT+1 MSBs. guard = next bit; sticky = OR of the remaining bits (0 if C_INT ≤ C_MANT+1).
- Round-up decision by mode:
  - RNE: guard & (sticky | lsb).
  - Trunc: never.
  - +inf: ~sign & (guard | sticky).
  - −inf: sign & (guard | sticky).
- Rounding carry out of the mantissa: mantissa becomes 0 and exp increments by 1.
- Inexact = guard | sticky.
- Zero operand: result is +0.0 (all zeros) in every mode, Inexact = 0.
- Latency is 3 cycles from an accepted input (Valid_SI & Ready_SO) to Valid_SO when there is no stall. Throughput is 1 per cycle.
- Stall: stage k advances when stage k+1 is empty or advancing. The output stage advances when Ready_SI is high.
  - Ready_SO = ~S1.valid | S1 advancing.
  - A combinational path from Ready_SI to Ready_SO is permitted.
- Hold rule: while Valid_SO is high and Ready_SI is low, Result_DO and Inexact_SO are held stable.
- In-order delivery: no drop, no duplication.
- Reset:
  - All valid bits clear; Valid_SO = 0, Result_DO = 0, Inexact_SO = 0.
  - Ready_SO = 1 in the first cycle after reset is released.
  - Reset asserted mid-flight discards all in-flight operations, with no output.
- Simultaneous handshakes: an input accept and an output drain in the same cycle with a full pipe keeps the pipe full, and no bubble is inserted.
- Invalid input modes (a don't-care Signed_SI or RM_SI) are sampled only when Valid_SI is high.

Decomposition:
- Package fpu_defs_pkg holds:
  - rounding-mode constants C_RM_NEAREST, C_RM_TRUNC, C_RM_PLUSINF, C_RM_MINUSINF;
  - C_EXP, C_MANT, C_BIAS defaults;
  - the derived widths: lzc width = $clog2(C_INT), and the result width.
- One sub-module, fpu_lzc_n: parametrised-width combinational leading-zero counter, also reusable by fpu_ftoi and the adder normaliser.
- Rounding stays inline in S3.

Test Plan (float32, C_INT = 32):
- 0x00000001, signed, RNE -> 0x3F800000, inexact 0. 0xFFFFFFFF, signed, RNE -> 0xBF800000.
- 0x80000000, signed, any RM -> 0xCF000000, inexact 0. Same input, unsigned -> 0x4F000000.
- 0x01000001, unsigned:
  - RNE -> 0x4B800000 (tie to even).
  - Trunc -> 0x4B800000.
  - +inf -> 0x4B800001.
  - −inf -> 0x4B800000.
  - Inexact = 1 in all four cases.
- 0xFFFFFFFF, unsigned:
  - RNE -> 0x4F800000 (carry-out, exponent increments).
  - Trunc -> 0x4F7FFFFF.
  - Inexact = 1.
- 0x00000000 with each RM -> 0x00000000, inexact 0.
- Back-to-back random stream with Ready_SI toggled pseudo-randomly -> in-order results matching a reference model, outputs stable while stalled, 3-cycle latency when unstalled. Reset asserted with 3 operations in flight -> no Valid_SO afterwards, Ready_SO = 1.
